// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC pair scheduler.
//   sched_st_t : scheduler FSM states
//   TDC_W      : default sample width of mlt / mlt200
//   DIFF_W     : width of the datapath difference result
//   rr_next    : round-robin pick of the lowest requester at or after last+1
package tdc_pkg;

  localparam int unsigned TDC_W  = 37;
  localparam int unsigned DIFF_W = 20;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT,
    ST_GUARD
  } sched_st_t;

  // Requests above NCH are zero-padded, so wrapping modulo RR_MAX visits the
  // real channels in the same order as wrapping modulo NCH.
  function automatic logic [2:0] rr_next(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last);
    logic [2:0] idx;
    rr_next = last;
    // Descending scan: the closest requester after last is assigned last and wins.
    for (int k = RR_MAX; k >= 1; k--) begin
      idx = last + 3'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/tdc_pair_buf.sv
// One channel's 2-entry start/stop buffer with sticky overflow flag.
//   clk, rst_n          : clock, async active-low reset
//   i_dval              : sample strobe
//   i_mlt, i_mlt200     : sample
//   i_rel               : pair consumed by the scheduler, buffer released
//   i_granted           : channel currently owns the datapath
//   o_a_*, o_b_*        : first / second buffered sample
//   o_req_c             : complete pair waiting (combinational)
//   o_ovf               : sticky overflow flag
module tdc_pair_buf
  import tdc_pkg::*;
#(
  parameter int unsigned W = TDC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_dval,
  input  logic [W-1:0] i_mlt,
  input  logic [W-1:0] i_mlt200,
  input  logic         i_rel,
  input  logic         i_granted,
  output logic [W-1:0] o_a_mlt,
  output logic [W-1:0] o_a_mlt200,
  output logic [W-1:0] o_b_mlt,
  output logic [W-1:0] o_b_mlt200,
  output logic         o_req_c,
  output logic         o_ovf
);

  logic [1:0] r_cnt;

  // Fill / release / overflow bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      o_ovf      <= 1'b0;
      o_a_mlt    <= '0;
      o_a_mlt200 <= '0;
      o_b_mlt    <= '0;
      o_b_mlt200 <= '0;
    end else if (i_rel) begin
      // A strobe coinciding with release starts the next pair
      if (i_dval) begin
        o_a_mlt    <= i_mlt;
        o_a_mlt200 <= i_mlt200;
        r_cnt      <= 2'd1;
      end else begin
        r_cnt      <= 2'd0;
      end
    end else if (i_dval) begin
      case (r_cnt)
        2'd0: begin
          o_a_mlt    <= i_mlt;
          o_a_mlt200 <= i_mlt200;
          r_cnt      <= 2'd1;
        end
        2'd1: begin
          o_b_mlt    <= i_mlt;
          o_b_mlt200 <= i_mlt200;
          r_cnt      <= 2'd2;
        end
        default: begin
          // Full: sample is dropped; only flagged when nobody is serving us
          if (!i_granted) o_ovf <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_c = (r_cnt == 2'd2);

endmodule

// File: rtl/tdc_pair_sched.sv
// Round-robin scheduler sharing one pair-difference datapath among NCH channels.
//   clk, rst              : clock, async active-low reset
//   ch_dval/mlt/mlt200    : per-channel sample strobes and samples (flattened)
//   dp_dval/mlt/mlt200    : pair issued to the datapath, A then B
//   dp_data               : datapath result, captured LAT edges after B
//   out_data/ch/dval      : captured result with channel tag, one-cycle strobe
//   ovf                   : sticky per-channel overflow flags
module tdc_pair_sched
  import tdc_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned W     = TDC_W,
  parameter int unsigned LAT   = 3,
  parameter int unsigned GUARD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           ch_dval,
  input  logic [NCH*W-1:0]         ch_mlt,
  input  logic [NCH*W-1:0]         ch_mlt200,
  output logic                     dp_dval,
  output logic [W-1:0]             dp_mlt,
  output logic [W-1:0]             dp_mlt200,
  input  logic [DIFF_W-1:0]        dp_data,
  output logic [DIFF_W-1:0]        out_data,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     out_dval,
  output logic [NCH-1:0]           ovf
);

  localparam int unsigned CW    = $clog2(NCH);
  localparam int unsigned CNT_W = 8;

  sched_st_t          r_state, w_nxt_state;
  logic [CW-1:0]      r_last, w_nxt_last, w_pick;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic               w_nxt_dval, w_nxt_out_dval;
  logic [W-1:0]       w_nxt_mlt, w_nxt_mlt200;
  logic [DIFF_W-1:0]  w_nxt_out_data;
  logic [CW-1:0]      w_nxt_out_ch;
  logic [RR_MAX-1:0]  w_req_pad;

  logic [W-1:0]       w_a_mlt [NCH];
  logic [W-1:0]       w_a_mlt200 [NCH];
  logic [W-1:0]       w_b_mlt [NCH];
  logic [W-1:0]       w_b_mlt200 [NCH];
  logic [NCH-1:0]     w_req, w_rel, w_granted;

  for (genvar i = 0; i < NCH; i++) begin : g_buf
    tdc_pair_buf #(.W(W)) u_buf (
      .clk        (clk),
      .rst_n      (rst),
      .i_dval     (ch_dval[i]),
      .i_mlt      (ch_mlt[i*W +: W]),
      .i_mlt200   (ch_mlt200[i*W +: W]),
      .i_rel      (w_rel[i]),
      .i_granted  (w_granted[i]),
      .o_a_mlt    (w_a_mlt[i]),
      .o_a_mlt200 (w_a_mlt200[i]),
      .o_b_mlt    (w_b_mlt[i]),
      .o_b_mlt200 (w_b_mlt200[i]),
      .o_req_c    (w_req[i]),
      .o_ovf      (ovf[i])
    );
  end

  // Grant decode; r_last doubles as the current grant while a pair is in flight
  always_comb begin
    w_rel     = '0;
    w_granted = '0;
    w_req_pad = '0;
    w_req_pad[NCH-1:0] = w_req;
    for (int i = 0; i < NCH; i++) begin
      w_rel[i]     = (r_state == ST_SEND_B) && (r_last == CW'(i));
      w_granted[i] = ((r_state == ST_SEND_A) || (r_state == ST_SEND_B)) &&
                     (r_last == CW'(i));
    end
    w_pick = CW'(rr_next(w_req_pad, 3'(r_last)));
  end

  // Next-state and registered-output values
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_last     = r_last;
    w_nxt_cnt      = r_cnt;
    w_nxt_dval     = 1'b0;
    w_nxt_mlt      = dp_mlt;
    w_nxt_mlt200   = dp_mlt200;
    w_nxt_out_data = out_data;
    w_nxt_out_ch   = out_ch;
    w_nxt_out_dval = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_nxt_state  = ST_SEND_A;
          w_nxt_last   = w_pick;
          w_nxt_dval   = 1'b1;
          w_nxt_mlt    = w_a_mlt[w_pick];
          w_nxt_mlt200 = w_a_mlt200[w_pick];
        end
      end
      ST_SEND_A: begin
        w_nxt_state  = ST_SEND_B;
        w_nxt_dval   = 1'b1;
        w_nxt_mlt    = w_b_mlt[r_last];
        w_nxt_mlt200 = w_b_mlt200[r_last];
      end
      ST_SEND_B: begin
        w_nxt_state = ST_WAIT;
        w_nxt_cnt   = '0;
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(LAT - 1)) begin
          w_nxt_state    = ST_GUARD;
          w_nxt_cnt      = '0;
          w_nxt_out_data = dp_data;
          w_nxt_out_ch   = r_last;
          w_nxt_out_dval = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_GUARD: begin
        if (r_cnt == CNT_W'(GUARD - 1)) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_last    <= CW'(NCH - 1);
      r_cnt     <= '0;
      dp_dval   <= 1'b0;
      dp_mlt    <= '0;
      dp_mlt200 <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_dval  <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_last    <= w_nxt_last;
      r_cnt     <= w_nxt_cnt;
      dp_dval   <= w_nxt_dval;
      dp_mlt    <= w_nxt_mlt;
      dp_mlt200 <= w_nxt_mlt200;
      out_data  <= w_nxt_out_data;
      out_ch    <= w_nxt_out_ch;
      out_dval  <= w_nxt_out_dval;
    end
  end

endmodule

// File: tb/tb_tdc_pair_sched.sv
// Scoreboard bench for tdc_pair_sched with a behavioural B-minus-A datapath.
module tb_tdc_pair_sched;

  localparam int unsigned NCH   = 4;
  localparam int unsigned W     = 37;
  localparam int unsigned LAT   = 3;
  localparam int unsigned GUARD = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     ch_dval;
  logic [NCH*W-1:0]   ch_mlt, ch_mlt200;
  logic               dp_dval;
  logic [W-1:0]       dp_mlt, dp_mlt200;
  logic [19:0]        dp_data;
  logic [19:0]        out_data;
  logic [1:0]         out_ch;
  logic               out_dval;
  logic [NCH-1:0]     ovf;

  tdc_pair_sched #(.NCH(NCH), .W(W), .LAT(LAT), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_dval   (ch_dval),
    .ch_mlt    (ch_mlt),
    .ch_mlt200 (ch_mlt200),
    .dp_dval   (dp_dval),
    .dp_mlt    (dp_mlt),
    .dp_mlt200 (dp_mlt200),
    .dp_data   (dp_data),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_dval  (out_dval),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Datapath model: pairs by parity, result valid only on the capture cycle
  logic        dpm_par;
  logic [19:0] dpm_a;
  logic [19:0] pd [LAT];
  logic        pv [LAT];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dpm_par <= 1'b0;
      dpm_a   <= '0;
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= 1'b0;
      if (dp_dval) begin
        if (!dpm_par) begin
          dpm_a   <= 20'(dp_mlt - dp_mlt200);
          dpm_par <= 1'b1;
        end else begin
          pd[0]   <= 20'(dp_mlt - dp_mlt200) - dpm_a;
          pv[0]   <= 1'b1;
          dpm_par <= 1'b0;
        end
      end
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign dp_data = pv[LAT-1] ? pd[LAT-1] : 20'hFFFFF;

  typedef struct packed {
    logic [1:0]  ch;
    logic [19:0] d;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  int     starts[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     run = 0;
  logic   prev_dv = 1'b0;
  bit     ok;

  logic [W-1:0] sm [NCH];
  logic [W-1:0] sr [NCH];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each result and measures dp_dval bursts
  always @(negedge clk) begin
    cyc++;
    if (out_dval) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: ch %0d data %0d with nothing expected", out_ch, out_data);
      end else begin
        e = q.pop_front();
        chk("out_ch", longint'(out_ch), longint'(e.ch));
        chk("out_data", longint'(out_data), longint'(e.d));
      end
    end
    if (dp_dval && !prev_dv) begin
      starts.push_back(cyc);
      run = 1;
    end else if (dp_dval) begin
      run++;
    end else if (prev_dv) begin
      chk("dp_dval_len", longint'(run), 2);
    end
    prev_dv = dp_dval;
  end

  task automatic strobe(input logic [NCH-1:0] mask);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      ch_mlt[c*W +: W]    = sm[c];
      ch_mlt200[c*W +: W] = sr[c];
    end
    ch_dval = mask;
    @(negedge clk);
    ch_dval = '0;
  endtask

  task automatic one(input int c, input longint m, input longint r);
    logic [NCH-1:0] mk;
    mk    = '0;
    mk[c] = 1'b1;
    sm[c] = W'(m);
    sr[c] = W'(r);
    strobe(mk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    ch_dval = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", nm, q.size());
      q.delete();
    end
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic wait_dv(output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dp_dval) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL dp_dval_timeout: dp_dval stayed 0, required 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    ch_dval   = '0;
    ch_mlt    = '0;
    ch_mlt200 = '0;
    for (int c = 0; c < NCH; c++) begin
      sm[c] = '0;
      sr[c] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_dp_dval", longint'(dp_dval), 0);
    chk("rst_out_dval", longint'(out_dval), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_ch", longint'(out_ch), 0);
    chk("rst_dp_mlt", longint'(dp_mlt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single pair on ch0: 1250 - 1000
    starts.delete();
    q.push_back(exp_t'{ch: 2'd0, d: 20'd250});
    one(0, 1000, 0);
    one(0, 1250, 0);
    wait_drain("t1");
    chk("t1_issue_count", longint'(starts.size()), 1);

    // ch1 and ch3 complete together: ch1 first, ch3 second with negative diff
    do_reset();
    starts.delete();
    q.push_back(exp_t'{ch: 2'd1, d: 20'd400});
    q.push_back(exp_t'{ch: 2'd3, d: 20'hFFC18});
    sm[1] = W'(500);  sr[1] = W'(100);
    sm[3] = W'(3000); sr[3] = W'(0);
    strobe(4'b1010);
    sm[1] = W'(900);  sr[1] = W'(100);
    sm[3] = W'(2000); sr[3] = W'(0);
    strobe(4'b1010);
    wait_drain("t2");
    chk("t2_issue_count", longint'(starts.size()), 2);
    if (starts.size() == 2) chk("t2_issue_spacing", longint'(starts[1] - starts[0]), 10);

    // ch2 overflows while ch0 is served; third sample dropped
    do_reset();
    q.push_back(exp_t'{ch: 2'd0, d: 20'd20});
    q.push_back(exp_t'{ch: 2'd2, d: 20'd200});
    one(0, 40, 0);
    one(0, 60, 0);
    one(2, 700, 0);
    one(2, 1000, 100);
    one(2, 5555, 0);
    wait_drain("t3");
    chk("t3_ovf", longint'(ovf), 4);

    // ch0 strobe during its SEND_B becomes the next A
    do_reset();
    q.push_back(exp_t'{ch: 2'd0, d: 20'd200});
    q.push_back(exp_t'{ch: 2'd0, d: 20'd2500});
    one(0, 100, 0);
    one(0, 300, 0);
    wait_dv(ok);
    one(0, 5000, 1000);
    one(0, 7000, 500);
    wait_drain("t4");
    chk("t4_ovf", longint'(ovf), 0);

    // 100 pairs across all channels, grants rotate 0..3
    do_reset();
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < NCH; c++) begin
        sm[c] = W'(r * 100 + c);
        sr[c] = '0;
      end
      strobe(4'hF);
      for (int c = 0; c < NCH; c++) begin
        sm[c] = W'(r * 100 + c + 17 * (c + 1) + r);
        q.push_back(exp_t'{ch: 2'(c), d: 20'(17 * (c + 1) + r)});
      end
      strobe(4'hF);
      wait_drain("t5");
    end
    chk("t5_ovf", longint'(ovf), 0);

    // Reset during WAIT aborts the pair and clears partial buffers
    do_reset();
    one(1, 9999, 0);
    one(0, 100, 0);
    one(0, 150, 0);
    wait_dv(ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_dp_dval", longint'(dp_dval), 0);
    chk("t6_rst_out_dval", longint'(out_dval), 0);
    chk("t6_rst_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    q.push_back(exp_t'{ch: 2'd1, d: 20'd650});
    one(1, 2000, 100);
    one(1, 2600, 50);
    wait_drain("t6");

    chk("queue_empty", longint'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdc_pair_sched.md
# tdc_pair_sched

Round-robin scheduler that shares one pair-difference datapath (`mlt`/`mlt200` in, 20-bit difference out) between NCH TDC channels. Each channel's samples are buffered as start/stop pairs. Complete pairs are issued to the datapath back-to-back, so its internal pair parity never interleaves two channels. The datapath result is captured at a fixed latency and returned tagged with the originating channel. The block sits between the per-channel TDC front ends and the shared difference unit.

## Interface
- `NCH`, 4: number of requesting channels (2..8)
- `W`, 37: sample width of `mlt` / `mlt200`
- `LAT`, 3: rising edges from the edge that samples the second `dp_dval` to the edge that captures `dp_data`
- `GUARD`, 4: idle cycles after capture before the next grant
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ch_dval`  in  NCH  per-channel sample strobe, one cycle per sample
- `ch_mlt`  in  NCH×W  per-channel sample
- `ch_mlt200`  in  NCH×W  per-channel reference sample
- `dp_dval`  out  1  strobe to the datapath
- `dp_mlt`, `dp_mlt200`  out  W each  sample to the datapath
- `dp_data`  in  20  datapath difference result
- `out_data`  out  20  captured result
- `out_ch`  out  $clog2(NCH)  channel tag of `out_data`
- `out_dval`  out  1  one-cycle result strobe
- `ovf`  out  NCH  sticky per-channel overflow flags

## Operation
- Per-channel buffer has 2 entries (A = first sample, B = second) and a fill count of 0..2. `ch_dval` writes the entry at the current fill count. The channel requests service when its count is 2.
- A `ch_dval` arriving at count 2 while not granted: sample dropped, `ovf[i]` set. The flag clears only on reset.
- A `ch_dval` arriving on the same cycle the channel's buffer is released: the sample is written as the new A, count becomes 1.
- FSM states:
  - IDLE: if any request is pending, grant the lowest index at or after `last+1` (mod NCH) → SEND_A.
  - SEND_A: `dp_dval`=1 with entry A → SEND_B.
  - SEND_B: `dp_dval`=1 with entry B; buffer released → WAIT.
  - WAIT: count LAT edges, then latch `dp_data` and pulse `out_dval` with `out_ch`=grant → GUARD.
  - GUARD: GUARD cycles → IDLE.
- `last` updates to the granted index on entry to SEND_A. `last` resets to NCH-1, so channel 0 has first priority.
- Pair ordering is fixed: A is always sent before B. The datapath therefore always sees the pair as second minus first.
- `dp_mlt`/`dp_mlt200` hold their last value when `dp_dval`=0.

## Timing
- All outputs are registered. Reset value is 0 for all outputs, the FSM state (IDLE), all fill counts and all `ovf` bits.
- Issue latency: a request present in IDLE at edge n gives `dp_dval` high during cycles n+1 and n+2.
- Result: `out_dval` is high on the cycle after the capture edge.
- Issue-to-issue minimum is 2 + LAT + 1 + GUARD cycles (10 with defaults).
- Reset asserted mid-sequence aborts the pair and empties all buffers. The datapath is reset by the same `rst`, so parity stays aligned.

## Structure
- Shared package `tdc_pkg`:
  - FSM state enum `sched_st_t`
  - localparams `TDC_W`=37, `DIFF_W`=20
  - function `rr_next(req, last)`
- One sub-module `tdc_pair_buf`: one 2-entry channel buffer with overflow flag, instantiated NCH times.
- The arbiter stays inline.

## Test plan
- Single pair, ch0 (A: mlt=1000, mlt200=0; B: mlt=1250, mlt200=0), datapath model = B−A at LAT 3 → `out_data`=250, `out_ch`=0, one `out_dval` pulse, `dp_dval` exactly 2 cycles.
- ch1 and ch3 complete pairs on the same cycle after reset → ch1 served first, then ch3. Issue starts are 10 cycles apart.
- ch2 receives 3 strobes before it is granted (ch0 busy) → `ovf[2]`=1, third sample dropped. Delivered pair is the first two samples.
- ch0 strobes on the same cycle as its SEND_B → that sample becomes the next A. The following pair is computed correctly.
- All 4 channels pair continuously for 100 pairs → grants rotate 0,1,2,3,… with no `ovf` and every tag matching.
- `rst` low during WAIT → no `out_dval`, all fill counts 0. The next pair after release is correct.
